// File: rtl/br_stack_ctl.sv
// Branch and return-stack controller: conditional JP/CALL/RET against a latched
// ZE/CA/SG flag register, with a LIFO return stack and sticky overflow/underflow flags.
module br_stack_ctl #(
    parameter int            AW       = 16,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0,
    localparam int           SPW      = $clog2(DEPTH + 1),
    localparam int           IW       = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           req,
    input  logic [1:0]     kind,
    input  logic           p,
    input  logic [1:0]     ff,
    input  logic [AW-1:0]  tgt,
    input  logic           ze,
    input  logic           ca,
    input  logic           sg,
    input  logic           flag_we,
    output logic [AW-1:0]  pc,
    output logic           taken,
    output logic [SPW-1:0] sp,
    output logic           ovf,
    output logic           unf
);

    localparam logic [1:0] K_JP   = 2'b00;
    localparam logic [1:0] K_CALL = 2'b01;
    localparam logic [1:0] K_RET  = 2'b10;
    localparam logic [1:0] K_RSV  = 2'b11;

    localparam logic [1:0] F_UC = 2'b00;
    localparam logic [1:0] F_ZE = 2'b01;
    localparam logic [1:0] F_CA = 2'b10;
    localparam logic [1:0] F_SG = 2'b11;

    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    logic          fz, fc, fs;
    logic          flag_sel;
    logic          cond;
    logic          go;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [AW-1:0] pc_inc;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic [AW-1:0] stk [DEPTH];

    // Condition reads the flag register as it stood before this edge.
    always_comb begin
        flag_sel = 1'b0;
        case (ff)
            F_ZE:    flag_sel = fz;
            F_CA:    flag_sel = fc;
            F_SG:    flag_sel = fs;
            default: flag_sel = 1'b0;
        endcase
    end

    assign cond   = (ff == F_UC) ? 1'b1 : (flag_sel == p);
    assign go     = en & req & cond & (kind != K_RSV);
    assign full   = (sp == SP_FULL);
    assign empty  = (sp == '0);
    assign push   = go & (kind == K_CALL) & ~full;
    assign pop    = go & (kind == K_RET) & ~empty;
    assign pc_inc = pc + AW'(1);
    assign wr_idx = sp[IW-1:0];
    assign rd_idx = wr_idx - IW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            sp    <= '0;
            taken <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            fz    <= 1'b0;
            fc    <= 1'b0;
            fs    <= 1'b0;
        end else if (en) begin
            if (flag_we) begin
                fz <= ze;
                fc <= ca;
                fs <= sg;
            end
            pc    <= pc_inc;
            taken <= 1'b0;
            if (go) begin
                case (kind)
                    K_JP: begin
                        pc    <= tgt;
                        taken <= 1'b1;
                    end
                    K_CALL: begin
                        if (!full) begin
                            sp    <= sp + SPW'(1);
                            pc    <= tgt;
                            taken <= 1'b1;
                        end else begin
                            ovf <= 1'b1;
                        end
                    end
                    K_RET: begin
                        if (!empty) begin
                            sp    <= sp - SPW'(1);
                            pc    <= stk[rd_idx];
                            taken <= 1'b1;
                        end else begin
                            unf <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end else begin
            taken <= 1'b0;
        end
    end

    // Stack contents need no reset; entries at or above sp are never read.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            stk[wr_idx] <= pc_inc;
        end
    end

    logic unused_pop;
    assign unused_pop = pop;

endmodule

// File: tb/tb_br_stack_ctl.sv
// Directed bench for br_stack_ctl (AW=8, DEPTH=4): sequencing, flag conditions,
// call/return stack limits, stall, wrap and reset priority.
module tb_br_stack_ctl;

    localparam int AW = 8;
    localparam int DEPTH = 4;
    localparam int SPW = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           rst_n, en, req, p, ze, ca, sg, flag_we;
    logic [1:0]     kind, ff;
    logic [AW-1:0]  tgt;
    logic [AW-1:0]  pc;
    logic           taken, ovf, unf;
    logic [SPW-1:0] sp;

    int errors = 0;
    int checks = 0;

    br_stack_ctl #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(8'h00)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .kind(kind), .p(p),
        .ff(ff), .tgt(tgt), .ze(ze), .ca(ca), .sg(sg), .flag_we(flag_we),
        .pc(pc), .taken(taken), .sp(sp), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = 1'b0; kind = 2'b00; p = 1'b0; ff = 2'b00; tgt = '0;
        flag_we = 1'b0; ze = 1'b0; ca = 1'b0; sg = 1'b0;
    endtask

    task automatic branch(input logic [1:0] k, input logic pp, input logic [1:0] f,
                          input logic [AW-1:0] t);
        req = 1'b1; kind = k; p = pp; ff = f; tgt = t;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; idle();
        branch(2'b00, 1'b0, 2'b00, 8'h77);
        tick();
        checks++;
        if (pc !== 8'h00 || sp !== 3'd0 || taken !== 1'b0 || ovf !== 1'b0 || unf !== 1'b0) begin
            errors++;
            $display("FAIL reset: pc=%h sp=%0d taken=%b ovf=%b unf=%b, need 00 0 0 0 0",
                     pc, sp, taken, ovf, unf);
        end
        rst_n = 1'b1; idle();
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (pc !== AW'(i) || taken !== 1'b0) begin
                errors++;
                $display("FAIL seq_%0d: pc=%h taken=%b, need %h 0", i, pc, taken, AW'(i));
            end
        end
    endtask

    task automatic test_flag_branch();
        flag_we = 1'b1; ze = 1'b1;
        tick();
        idle();
        branch(2'b00, 1'b1, 2'b01, 8'h40);
        tick();
        checks++;
        if (pc !== 8'h40 || taken !== 1'b1) begin
            errors++;
            $display("FAIL jp_ze_taken: pc=%h taken=%b, need 40 1", pc, taken);
        end
        idle();
        tick();
        checks++;
        if (pc !== 8'h41 || taken !== 1'b0) begin
            errors++;
            $display("FAIL taken_one_cycle: pc=%h taken=%b, need 41 0", pc, taken);
        end
        branch(2'b00, 1'b0, 2'b01, 8'h80);
        tick();
        checks++;
        if (pc !== 8'h42 || taken !== 1'b0) begin
            errors++;
            $display("FAIL jp_ze_inv: pc=%h taken=%b, need 42 0", pc, taken);
        end
    endtask

    task automatic test_same_cycle_flag();
        idle();
        flag_we = 1'b1; ze = 1'b0;
        tick();
        flag_we = 1'b1; ze = 1'b1;
        branch(2'b00, 1'b1, 2'b01, 8'h80);
        tick();
        checks++;
        if (pc !== 8'h44 || taken !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_flag: pc=%h taken=%b, need 44 0", pc, taken);
        end
        flag_we = 1'b0;
        tick();
        checks++;
        if (pc !== 8'h80 || taken !== 1'b1) begin
            errors++;
            $display("FAIL flag_after_load: pc=%h taken=%b, need 80 1", pc, taken);
        end
    endtask

    task automatic test_ca_sg();
        idle();
        flag_we = 1'b1; ze = 1'b0; ca = 1'b1; sg = 1'b0;
        tick();
        idle();
        branch(2'b00, 1'b1, 2'b10, 8'h90);
        tick();
        checks++;
        if (pc !== 8'h90 || taken !== 1'b1) begin
            errors++;
            $display("FAIL jp_ca: pc=%h taken=%b, need 90 1", pc, taken);
        end
        branch(2'b00, 1'b1, 2'b11, 8'hA0);
        tick();
        checks++;
        if (pc !== 8'h91 || taken !== 1'b0) begin
            errors++;
            $display("FAIL jp_sg_p1: pc=%h taken=%b, need 91 0", pc, taken);
        end
        branch(2'b00, 1'b0, 2'b11, 8'hA0);
        tick();
        checks++;
        if (pc !== 8'hA0 || taken !== 1'b1) begin
            errors++;
            $display("FAIL jp_sg_p0: pc=%h taken=%b, need a0 1", pc, taken);
        end
        branch(2'b00, 1'b0, 2'b01, 8'hB0);
        tick();
        checks++;
        if (pc !== 8'hB0 || taken !== 1'b1) begin
            errors++;
            $display("FAIL jp_ze_clear: pc=%h taken=%b, need b0 1", pc, taken);
        end
    endtask

    task automatic test_stall();
        en = 1'b0;
        branch(2'b01, 1'b0, 2'b00, 8'h99);
        flag_we = 1'b1; ze = 1'b1;
        tick();
        tick();
        checks++;
        if (pc !== 8'hB0 || taken !== 1'b0 || sp !== 3'd0) begin
            errors++;
            $display("FAIL stall: pc=%h taken=%b sp=%0d, need b0 0 0", pc, taken, sp);
        end
        en = 1'b1; idle();
        branch(2'b00, 1'b1, 2'b01, 8'hC0);
        tick();
        checks++;
        if (pc !== 8'hB1 || taken !== 1'b0) begin
            errors++;
            $display("FAIL stall_flag_hold: pc=%h taken=%b, need b1 0", pc, taken);
        end
    endtask

    task automatic test_call_ret();
        logic [AW-1:0] ret_exp [4];
        ret_exp[0] = 8'h41; ret_exp[1] = 8'h31; ret_exp[2] = 8'h21; ret_exp[3] = 8'h11;
        idle();
        branch(2'b00, 1'b0, 2'b00, 8'h10);
        tick();
        for (int i = 1; i <= 4; i++) begin
            branch(2'b01, 1'b0, 2'b00, AW'((i + 1) * 16));
            tick();
            checks++;
            if (pc !== AW'((i + 1) * 16) || sp !== SPW'(i) || taken !== 1'b1) begin
                errors++;
                $display("FAIL call_%0d: pc=%h sp=%0d taken=%b, need %h %0d 1",
                         i, pc, sp, taken, AW'((i + 1) * 16), i);
            end
        end
        branch(2'b01, 1'b0, 2'b00, 8'h60);
        tick();
        checks++;
        if (pc !== 8'h51 || sp !== 3'd4 || taken !== 1'b0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL call_ovf: pc=%h sp=%0d taken=%b ovf=%b, need 51 4 0 1",
                     pc, sp, taken, ovf);
        end
        for (int i = 0; i < 4; i++) begin
            branch(2'b10, 1'b0, 2'b00, 8'hEE);
            tick();
            checks++;
            if (pc !== ret_exp[i] || sp !== SPW'(3 - i) || taken !== 1'b1) begin
                errors++;
                $display("FAIL ret_%0d: pc=%h sp=%0d taken=%b, need %h %0d 1",
                         i, pc, sp, taken, ret_exp[i], 3 - i);
            end
        end
    endtask

    task automatic test_underflow();
        branch(2'b10, 1'b0, 2'b00, 8'hEE);
        tick();
        checks++;
        if (pc !== 8'h12 || sp !== 3'd0 || taken !== 1'b0 || unf !== 1'b1) begin
            errors++;
            $display("FAIL ret_unf: pc=%h sp=%0d taken=%b unf=%b, need 12 0 0 1",
                     pc, sp, taken, unf);
        end
        branch(2'b00, 1'b0, 2'b00, 8'h70);
        tick();
        checks++;
        if (pc !== 8'h70 || taken !== 1'b1 || ovf !== 1'b1 || unf !== 1'b1) begin
            errors++;
            $display("FAIL jp_after_unf: pc=%h taken=%b ovf=%b unf=%b, need 70 1 1 1",
                     pc, taken, ovf, unf);
        end
        branch(2'b11, 1'b0, 2'b00, 8'h33);
        tick();
        checks++;
        if (pc !== 8'h71 || taken !== 1'b0 || sp !== 3'd0) begin
            errors++;
            $display("FAIL reserved_kind: pc=%h taken=%b sp=%0d, need 71 0 0", pc, taken, sp);
        end
        branch(2'b01, 1'b1, 2'b01, 8'h33);
        tick();
        checks++;
        if (pc !== 8'h72 || taken !== 1'b0 || sp !== 3'd0) begin
            errors++;
            $display("FAIL call_cond_false: pc=%h taken=%b sp=%0d, need 72 0 0", pc, taken, sp);
        end
    endtask

    task automatic test_wrap();
        branch(2'b00, 1'b0, 2'b00, 8'hFF);
        tick();
        idle();
        tick();
        checks++;
        if (pc !== 8'h00 || taken !== 1'b0) begin
            errors++;
            $display("FAIL pc_wrap: pc=%h taken=%b, need 00 0", pc, taken);
        end
    endtask

    task automatic test_reset_mid_call();
        branch(2'b01, 1'b0, 2'b00, 8'h30);
        tick();
        checks++;
        if (pc !== 8'h30 || sp !== 3'd1) begin
            errors++;
            $display("FAIL pre_reset_call: pc=%h sp=%0d, need 30 1", pc, sp);
        end
        rst_n = 1'b0;
        branch(2'b01, 1'b0, 2'b00, 8'h55);
        flag_we = 1'b1; ze = 1'b1;
        tick();
        checks++;
        if (pc !== 8'h00 || sp !== 3'd0 || taken !== 1'b0 || ovf !== 1'b0 || unf !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_call: pc=%h sp=%0d taken=%b ovf=%b unf=%b, need 00 0 0 0 0",
                     pc, sp, taken, ovf, unf);
        end
        rst_n = 1'b1; idle();
        branch(2'b00, 1'b1, 2'b01, 8'h66);
        tick();
        checks++;
        if (pc !== 8'h01 || taken !== 1'b0) begin
            errors++;
            $display("FAIL flags_cleared: pc=%h taken=%b, need 01 0", pc, taken);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_flag_branch();
        test_same_cycle_flag();
        test_ca_sg();
        test_stall();
        test_call_ret();
        test_underflow();
        test_wrap();
        test_reset_mid_call();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/br_stack_ctl.md
BR_STACK_CTL -- requirements
Module: br_stack_ctl

Interface
REQ-001 Parameter AW, default 16: PC width in bits, legal range 8..32.
REQ-002 Parameter DEPTH, default 4: return-stack entries, legal range 2..16.
REQ-003 Parameter RESET_PC, default 0: PC value loaded at reset, AW bits.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 en  in  1  advance enable; 0 means stall, and all state holds.
REQ-008 req  in  1  branch request valid this cycle.
REQ-009 kind  in  2  00 JP, 01 CALL, 10 RET, 11 reserved (not taken).
REQ-010 p  in  1  polarity: 1 means take when flag=1, 0 means take when flag=0.
REQ-011 ff  in  2  condition select: 00 UC, 01 ZE, 10 CA, 11 SG.
REQ-012 tgt  in  AW  branch target for JP and CALL; ignored for RET.
REQ-013 ze, ca, sg  in  1 each  ALU status flags.
REQ-014 flag_we  in  1  latch ze/ca/sg into the flag register.
REQ-015 pc  out  AW  registered program counter.
REQ-016 taken  out  1  registered; 1 for one cycle after a taken branch.
REQ-017 sp  out  $clog2(DEPTH+1)  registered count of stack entries.
REQ-018 ovf  out  1  sticky flag: CALL attempted with the stack full.
REQ-019 unf  out  1  sticky flag: RET attempted with the stack empty.

Function
REQ-020 Flag register FZ/FC/FS SHALL load ze/ca/sg on a clock edge where en=1 and flag_we=1, and otherwise hold.
REQ-021 Condition cond SHALL be 1 when ff=UC; otherwise cond = (selected flag-register bit == p).
REQ-022 cond SHALL use the flag-register value from before the current edge, so a same-cycle flag_we does not affect it.
REQ-023 go = en & req & cond & (kind != 11).
REQ-024 JP with go SHALL set pc <= tgt.
REQ-025 CALL with go and sp<DEPTH SHALL push pc+1 mod 2^AW, set sp <= sp+1, and set pc <= tgt.
REQ-026 CALL with go and sp==DEPTH SHALL not push, SHALL set ovf, SHALL set pc <= pc+1, and SHALL be not taken.
REQ-027 RET with go and sp>0 SHALL set pc <= top entry and sp <= sp-1.
REQ-028 RET with go and sp==0 SHALL set unf, SHALL set pc <= pc+1, and SHALL be not taken.
REQ-029 When en=1 and no branch is taken, pc SHALL become pc+1 mod 2^AW; wrap from all-ones to 0 is silent.
REQ-030 taken SHALL be 1 on the cycle after an edge where the PC was loaded from tgt or the stack, and 0 otherwise, including during a stall.
REQ-031 Stack SHALL be LIFO, indexed by sp; entries above sp are don't-care.
REQ-032 en=0 SHALL override req and flag_we: no push, pop or flag change, and taken <= 0.
REQ-033 kind=11 and a false cond SHALL behave as sequential execution (pc+1) with no stack change.
REQ-034 ovf and unf SHALL stay set until reset; they SHALL not block later operations.
REQ-035 Latency: the new pc is visible one cycle after the request edge; there is no combinational path from inputs to outputs.

Reset
REQ-036 On a clock edge with rst_n=0: pc <= RESET_PC; sp, taken, ovf, unf, FZ, FC, FS <= 0; stack contents are don't-care.
REQ-037 Reset SHALL take priority over en, req and flag_we, including reset in the middle of a CALL or RET sequence.

Verification
REQ-038 Reset, then 3 cycles with en=1 and req=0 -> pc = 0,1,2,3; taken=0.
REQ-039 flag_we with ze=1, then JP with p=1, ff=ZE, tgt=0x40 -> pc=0x40 and taken=1 for one cycle; JP with p=0, ff=ZE -> pc+1.
REQ-040 Same cycle: flag_we with ze=1 while the register holds FZ=0, and JP with p=1, ff=ZE -> not taken; pc+1.
REQ-041 DEPTH=4: CALL at pc=0x10,0x20,0x30,0x40 (tgt=next) -> sp=4; a fifth CALL -> ovf=1 and pc+1; four RETs return 0x41,0x31,0x21,0x11.
REQ-042 RET with sp=0 -> unf=1, pc+1, taken=0; a following JP UC still executes.
REQ-043 AW=8, pc=0xFF, req=0 -> pc=0x00; rst_n=0 during a CALL cycle -> pc=RESET_PC and sp=0.
